mc_controller: RTL and testbench
================================

// Module: mc_controller
// PURPOSE
//  Multicycle MIPS control unit: the initiator side of the ALU interface. It decodes opcode/funct
//  and drives alucontrol, operand selects and datapath write enables one state per clock. It sits
//  between the instruction register and the 32-bit datapath (register file, ALU, memory, PC mux).
// PARAMETERS
//  SW = 4 : state register width; states encoded 0..13
// PORTS
//  clk        in  1  single clock, rising edge
//  rst_n      in  1  asynchronous, active-low reset
//  opcode     in  6  instr[31:26] from instruction register
//  funct      in  6  instr[5:0] from instruction register
//  zero       in  1  datapath flag, ALU out == 0
//  pcen       out 1  PC load = pcwrite | (branch & zero)
//  irwrite    out 1  instruction register load
//  memwrite   out 1  memory write strobe
//  regwrite   out 1  register file write
//  iord       out 1  memory address select: 0 = PC, 1 = ALUOut
//  memtoreg   out 1  writeback select: 1 = memory data
//  regdst     out 1  destination select: 1 = rd, 0 = rt
//  alusrca    out 1  srcA select: 0 = PC, 1 = regA
//  alusrcb    out 2  srcB select: 00 = regB, 01 = 4, 10 = imm ext, 11 = imm ext << 2
//  extop      out 1  immediate extension: 0 = sign, 1 = zero
//  pcsrc      out 2  00 = ALU out, 01 = ALUOut, 10 = jump target
//  alucontrol out 3  000 and, 001 or, 010 add, 011 sll, 100 nand, 101 nor, 110 sub, 111 slt
//  illegal    out 1  one-cycle pulse in DECODE on an unsupported opcode or funct
//  state_o    out SW current state, for debug and the bench
// BEHAVIOUR
//  - Moore FSM: every output is decoded from the state register, except pcen, which also uses zero.
//  - States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB,
//    JUMP, LOGIEXEC, LOGIWB.
//  - FETCH: iord=0, irwrite=1, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00, pcwrite=1.
//  - DECODE: alusrca=0, alusrcb=11, alucontrol=010 (branch target precompute).
//  - DECODE dispatch: lw/sw(100011/101011)->MEMADR; R(000000)->EXECUTE; beq(000100)->BRANCH;
//    addi(001000)->ADDIEXEC; j(000010)->JUMP; andi/ori(001100/001101)->LOGIEXEC (macro only).
//  - Any other opcode in DECODE: pulse illegal, next state FETCH, no write enable asserted.
//  - MEMADR: alusrca=1, alusrcb=10, add. Then lw->MEMRD(iord=1)->MEMWB(regwrite=1, memtoreg=1,
//    regdst=0)->FETCH; sw->MEMWR(iord=1, memwrite=1)->FETCH.
//  - EXECUTE: alusrca=1, alusrcb=00, alucontrol from funct; then ALUWB(regwrite=1, regdst=1)->FETCH.
//  - funct map: 100000 add->010, 100010 sub->110, 100100 and->000, 100101 or->001, 100111 nor->101,
//    101010 slt->111, 000000 sll->011.
//  - Unmapped funct: DECODE pulses illegal; EXECUTE drives 010 and ALUWB holds regwrite=0.
//  - BRANCH: alusrca=1, alusrcb=00, alucontrol=110, branch=1, pcsrc=01; pcen = zero; ->FETCH.
//  - ADDIEXEC: alusrca=1, alusrcb=10, add; ADDIWB: regwrite=1, regdst=0; ->FETCH.
//  - JUMP: pcsrc=10, pcwrite=1; ->FETCH.
//  - Cycles per instruction: lw 5; sw, R-type, addi, andi/ori 4; beq, j 3.
//  - Unlisted outputs are 0 in each state; alucontrol defaults to 010.
//  - Reset: rst_n low forces state FETCH asynchronously. While low, all enables (pcen, irwrite,
//    memwrite, regwrite) are 0, other selects are 0, alucontrol=010, illegal=0.
//  - The first edge after release executes FETCH. Reset mid-instruction abandons it with no
//    further writes.
//  - zero is sampled only in BRANCH; an X on zero elsewhere must not propagate to pcen.
// CONFIGURATION
//  MC_CTRL_IMM_LOGIC_EN defined: andi/ori are decoded.
//   - LOGIEXEC: alusrca=1, alusrcb=10, extop=1, alucontrol 000 (andi) or 001 (ori).
//   - LOGIWB: regwrite=1, regdst=0; ->FETCH.
//  Not defined: opcodes 001100/001101 are illegal; LOGI states are unreachable; extop tied 0.
// STRUCTURE
//  - Package mc_ctrl_pkg: opcode/funct localparams, state enum (SW bits), alucontrol code localparams.
//  - Sub-module alu_dec: combinational funct->{alucontrol, funct_ok}, instanced once.
// TESTING
//  1. Pulse rst_n low mid-MEMRD -> state_o=FETCH, memwrite=regwrite=0 immediately.
//     After release: irwrite=1, pcen=1.
//  2. lw (100011) -> FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 with memtoreg=1 only in MEMWB.
//  3. R-type funct 100010 -> alucontrol=110 in EXECUTE; ALUWB regwrite=1, regdst=1.
//     funct 111111 -> illegal pulse, regwrite stays 0.
//  4. beq with zero=1 -> pcen=1, pcsrc=01 in BRANCH. With zero=0 -> pcen=0. Next state FETCH.
//  5. opcode 111111 -> illegal=1 for one cycle in DECODE, then FETCH, no write enables.
//  6. ori (001101) with macro -> LOGIEXEC alucontrol=001, extop=1, then LOGIWB regwrite=1.
//     Without macro -> illegal pulse.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs, ALU codes and states.
// MC_CTRL_IMM_LOGIC_EN enables andi/ori decode in mc_controller.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_LOGIEXEC = 4'd12,
    S_LOGIWB   = 4'd13
  } state_e;

endpackage

// File: rtl/alu_dec.sv
// Combinational R-type funct decoder: ALU operation plus a flag saying the funct is supported.
module alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       funct_ok
);

  always_comb begin
    alucontrol = ALU_ADD;
    funct_ok   = 1'b1;
    case (funct)
      FN_ADD:  alucontrol = ALU_ADD;
      FN_SUB:  alucontrol = ALU_SUB;
      FN_AND:  alucontrol = ALU_AND;
      FN_OR:   alucontrol = ALU_OR;
      FN_NOR:  alucontrol = ALU_NOR;
      FN_SLT:  alucontrol = ALU_SLT;
      FN_SLL:  alucontrol = ALU_SLL;
      default: funct_ok   = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM (Moore); drives datapath selects/enables one state per clock.
// Define MC_CTRL_IMM_LOGIC_EN to decode andi/ori through LOGIEXEC/LOGIWB.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [5:0]    opcode,
  input  logic [5:0]    funct,
  input  logic          zero,
  output logic          pcen,
  output logic          irwrite,
  output logic          memwrite,
  output logic          regwrite,
  output logic          iord,
  output logic          memtoreg,
  output logic          regdst,
  output logic          alusrca,
  output logic [1:0]    alusrcb,
  output logic          extop,
  output logic [1:0]    pcsrc,
  output logic [2:0]    alucontrol,
  output logic          illegal,
  output logic [SW-1:0] state_o
);

  state_e     state_q, state_d;
  logic [2:0] funct_alu;
  logic       funct_ok;

  logic       pcwrite_s, branch_s, irwrite_s, memwrite_s, regwrite_s;
  logic       iord_s, memtoreg_s, regdst_s, alusrca_s, illegal_s;
  logic [1:0] alusrcb_s, pcsrc_s;
  logic [2:0] aluctl_s;

  alu_dec u_alu_dec (
    .funct      (funct),
    .alucontrol (funct_alu),
    .funct_ok   (funct_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
`ifdef MC_CTRL_IMM_LOGIC_EN
          OP_ANDI, OP_ORI: state_d = S_LOGIEXEC;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    state_d = S_MEMWB;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEXEC: state_d = S_ADDIWB;
      S_LOGIEXEC: state_d = S_LOGIWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pcwrite_s  = 1'b0;
    branch_s   = 1'b0;
    irwrite_s  = 1'b0;
    memwrite_s = 1'b0;
    regwrite_s = 1'b0;
    iord_s     = 1'b0;
    memtoreg_s = 1'b0;
    regdst_s   = 1'b0;
    alusrca_s  = 1'b0;
    alusrcb_s  = 2'b00;
    pcsrc_s    = 2'b00;
    aluctl_s   = ALU_ADD;
    illegal_s  = 1'b0;
    case (state_q)
      S_FETCH: begin
        irwrite_s = 1'b1;
        alusrcb_s = 2'b01;
        pcwrite_s = 1'b1;
      end
      S_DECODE: begin
        alusrcb_s = 2'b11;
        // An unsupported opcode is exactly one that dispatches straight back to FETCH.
        illegal_s = (state_d == S_FETCH) || ((opcode == OP_RTYPE) && !funct_ok);
      end
      S_MEMADR: begin
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
      end
      S_MEMRD: iord_s = 1'b1;
      S_MEMWB: begin
        regwrite_s = 1'b1;
        memtoreg_s = 1'b1;
      end
      S_MEMWR: begin
        iord_s     = 1'b1;
        memwrite_s = 1'b1;
      end
      S_EXECUTE: begin
        alusrca_s = 1'b1;
        aluctl_s  = funct_alu;
      end
      S_ALUWB: begin
        regwrite_s = funct_ok;
        regdst_s   = 1'b1;
      end
      S_BRANCH: begin
        alusrca_s = 1'b1;
        aluctl_s  = ALU_SUB;
        branch_s  = 1'b1;
        pcsrc_s   = 2'b01;
      end
      S_ADDIEXEC: begin
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
      end
      S_ADDIWB: regwrite_s = 1'b1;
      S_JUMP: begin
        pcsrc_s   = 2'b10;
        pcwrite_s = 1'b1;
      end
      S_LOGIEXEC: begin
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
        aluctl_s  = (opcode == OP_ORI) ? ALU_OR : ALU_AND;
      end
      S_LOGIWB: regwrite_s = 1'b1;
      default: ;
    endcase
  end

  // Outputs are forced quiet while reset is held, even though the state reads FETCH.
  assign pcen       = rst_n & (pcwrite_s | (branch_s ? zero : 1'b0));
  assign irwrite    = rst_n & irwrite_s;
  assign memwrite   = rst_n & memwrite_s;
  assign regwrite   = rst_n & regwrite_s;
  assign iord       = rst_n & iord_s;
  assign memtoreg   = rst_n & memtoreg_s;
  assign regdst     = rst_n & regdst_s;
  assign alusrca    = rst_n & alusrca_s;
  assign alusrcb    = rst_n ? alusrcb_s : 2'b00;
  assign pcsrc      = rst_n ? pcsrc_s : 2'b00;
  assign alucontrol = rst_n ? aluctl_s : ALU_ADD;
  assign illegal    = rst_n & illegal_s;
  assign state_o    = SW'(state_q);

`ifdef MC_CTRL_IMM_LOGIC_EN
  assign extop = rst_n & (state_q == S_LOGIEXEC);
`else
  assign extop = 1'b0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: stimulus queues expected per-cycle vectors, a monitor checks them.
`timescale 1ns/1ps
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero;
  logic       pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic       extop, illegal;
  logic [2:0] alucontrol;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  mc_controller #(.SW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .pcen       (pcen),
    .irwrite    (irwrite),
    .memwrite   (memwrite),
    .regwrite   (regwrite),
    .iord       (iord),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .extop      (extop),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .illegal    (illegal),
    .state_o    (state_o)
  );

  // en = {pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca}
  typedef struct packed {
    logic [3:0] st;
    logic [7:0] en;
    logic [1:0] b;
    logic       ex;
    logic [1:0] ps;
    logic [2:0] ac;
    logic       il;
  } vec_t;

  typedef struct {
    vec_t  v;
    string name;
  } item_t;

  item_t sb_q[$];
  int    checks = 0;
  int    failures = 0;
  event  sample_ev;
  vec_t  act;

  assign act = {state_o, pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca,
                alusrcb, extop, pcsrc, alucontrol, illegal};

  function automatic vec_t mk(input int st, input logic [7:0] en, input logic [1:0] b,
                              input logic ex, input logic [1:0] ps, input logic [2:0] ac,
                              input logic il);
    logic [3:0] s4;
    s4 = st[3:0];
    return {s4, en, b, ex, ps, ac, il};
  endfunction

  function automatic vec_t v_fetch();             return mk(0,  8'b1100_0000, 2'b01, 1'b0, 2'b00, 3'b010, 1'b0); endfunction
  function automatic vec_t v_decode(logic il);    return mk(1,  8'b0000_0000, 2'b11, 1'b0, 2'b00, 3'b010, il);   endfunction
  function automatic vec_t v_memadr();            return mk(2,  8'b0000_0001, 2'b10, 1'b0, 2'b00, 3'b010, 1'b0); endfunction
  function automatic vec_t v_memrd();             return mk(3,  8'b0000_1000, 2'b00, 1'b0, 2'b00, 3'b010, 1'b0); endfunction
  function automatic vec_t v_memwb();             return mk(4,  8'b0001_0100, 2'b00, 1'b0, 2'b00, 3'b010, 1'b0); endfunction
  function automatic vec_t v_memwr();             return mk(5,  8'b0010_1000, 2'b00, 1'b0, 2'b00, 3'b010, 1'b0); endfunction
  function automatic vec_t v_exec(logic [2:0] a); return mk(6,  8'b0000_0001, 2'b00, 1'b0, 2'b00, a,      1'b0); endfunction
  function automatic vec_t v_aluwb(logic rw);     return mk(7,  {3'b000, rw, 4'b0010}, 2'b00, 1'b0, 2'b00, 3'b010, 1'b0); endfunction
  function automatic vec_t v_branch(logic z);     return mk(8,  {z, 7'b000_0001}, 2'b00, 1'b0, 2'b01, 3'b110, 1'b0); endfunction
  function automatic vec_t v_addiexec();          return mk(9,  8'b0000_0001, 2'b10, 1'b0, 2'b00, 3'b010, 1'b0); endfunction
  function automatic vec_t v_addiwb();            return mk(10, 8'b0001_0000, 2'b00, 1'b0, 2'b00, 3'b010, 1'b0); endfunction
  function automatic vec_t v_jump();              return mk(11, 8'b1000_0000, 2'b00, 1'b0, 2'b10, 3'b010, 1'b0); endfunction
  function automatic vec_t v_rst();               return mk(0,  8'b0000_0000, 2'b00, 1'b0, 2'b00, 3'b010, 1'b0); endfunction
`ifdef MC_CTRL_IMM_LOGIC_EN
  function automatic vec_t v_logiexec(logic [2:0] a); return mk(12, 8'b0000_0001, 2'b10, 1'b1, 2'b00, a, 1'b0); endfunction
  function automatic vec_t v_logiwb();                return mk(13, 8'b0001_0000, 2'b00, 1'b0, 2'b00, 3'b010, 1'b0); endfunction
`endif

  task automatic push(input vec_t v, input string n);
    item_t it;
    it.v = v;
    it.name = n;
    sb_q.push_back(it);
  endtask

  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z);
    opcode = op;
    funct  = fn;
    zero   = z;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: one expected vector per falling edge, or on demand for asynchronous checks.
  initial begin
    forever begin
      item_t it;
      @(negedge clk or sample_ev);
      if (sb_q.size() > 0) begin
        it = sb_q.pop_front();
        checks++;
        if (act !== it.v) begin
          failures++;
          $display("FAIL %s: got st=%0d en=%b srcb=%b ext=%b pcsrc=%b alu=%b ill=%b, want st=%0d en=%b srcb=%b ext=%b pcsrc=%b alu=%b ill=%b",
                   it.name, act.st, act.en, act.b, act.ex, act.ps, act.ac, act.il,
                   it.v.st, it.v.en, it.v.b, it.v.ex, it.v.ps, it.v.ac, it.v.il);
        end else begin
          $display("ok   %s: st=%0d en=%b srcb=%b pcsrc=%b alu=%b ill=%b",
                   it.name, act.st, act.en, act.b, act.ps, act.ac, act.il);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    issue(6'b000000, 6'b000000, 1'b0);
    @(posedge clk); #1;
    push(v_rst(), "reset_hold"); -> sample_ev;
    #1 rst_n = 1'b1;
    #1;

    // lw with zero undriven: pcen must stay clean outside BRANCH
    issue(6'b100011, 6'b000000, 1'bx);
    push(v_fetch(), "lw_fetch"); push(v_decode(1'b0), "lw_decode"); push(v_memadr(), "lw_memadr");
    push(v_memrd(), "lw_memrd"); push(v_memwb(), "lw_memwb");
    run(5);

    issue(6'b101011, 6'b000000, 1'b0);
    push(v_fetch(), "sw_fetch"); push(v_decode(1'b0), "sw_decode"); push(v_memadr(), "sw_memadr");
    push(v_memwr(), "sw_memwr");
    run(4);

    issue(6'b000000, 6'b100010, 1'b0);
    push(v_fetch(), "sub_fetch"); push(v_decode(1'b0), "sub_decode"); push(v_exec(3'b110), "sub_exec");
    push(v_aluwb(1'b1), "sub_aluwb");
    run(4);

    issue(6'b000000, 6'b100100, 1'b1);
    push(v_fetch(), "and_fetch"); push(v_decode(1'b0), "and_decode"); push(v_exec(3'b000), "and_exec");
    push(v_aluwb(1'b1), "and_aluwb");
    run(4);

    issue(6'b000000, 6'b000000, 1'b0);
    push(v_fetch(), "sll_fetch"); push(v_decode(1'b0), "sll_decode"); push(v_exec(3'b011), "sll_exec");
    push(v_aluwb(1'b1), "sll_aluwb");
    run(4);

    issue(6'b000000, 6'b101010, 1'bx);
    push(v_fetch(), "slt_fetch"); push(v_decode(1'b0), "slt_decode"); push(v_exec(3'b111), "slt_exec");
    push(v_aluwb(1'b1), "slt_aluwb");
    run(4);

    issue(6'b000000, 6'b111111, 1'b0);
    push(v_fetch(), "badfn_fetch"); push(v_decode(1'b1), "badfn_decode"); push(v_exec(3'b010), "badfn_exec");
    push(v_aluwb(1'b0), "badfn_aluwb");
    run(4);

    issue(6'b000100, 6'b000000, 1'b1);
    push(v_fetch(), "beq1_fetch"); push(v_decode(1'b0), "beq1_decode"); push(v_branch(1'b1), "beq1_branch");
    run(3);

    issue(6'b000100, 6'b000000, 1'b0);
    push(v_fetch(), "beq0_fetch"); push(v_decode(1'b0), "beq0_decode"); push(v_branch(1'b0), "beq0_branch");
    run(3);

    issue(6'b001000, 6'b000000, 1'bx);
    push(v_fetch(), "addi_fetch"); push(v_decode(1'b0), "addi_decode"); push(v_addiexec(), "addi_exec");
    push(v_addiwb(), "addi_wb");
    run(4);

    issue(6'b000010, 6'b000000, 1'b0);
    push(v_fetch(), "j_fetch"); push(v_decode(1'b0), "j_decode"); push(v_jump(), "j_jump");
    run(3);

    issue(6'b111111, 6'b000000, 1'b0);
    push(v_fetch(), "badop_fetch"); push(v_decode(1'b1), "badop_decode");
    run(2);

`ifdef MC_CTRL_IMM_LOGIC_EN
    issue(6'b001101, 6'b000000, 1'b0);
    push(v_fetch(), "ori_fetch"); push(v_decode(1'b0), "ori_decode"); push(v_logiexec(3'b001), "ori_exec");
    push(v_logiwb(), "ori_wb");
    run(4);
    issue(6'b001100, 6'b000000, 1'b0);
    push(v_fetch(), "andi_fetch"); push(v_decode(1'b0), "andi_decode"); push(v_logiexec(3'b000), "andi_exec");
    push(v_logiwb(), "andi_wb");
    run(4);
`else
    issue(6'b001101, 6'b000000, 1'b0);
    push(v_fetch(), "ori_fetch"); push(v_decode(1'b1), "ori_illegal");
    run(2);
    issue(6'b001100, 6'b000000, 1'b0);
    push(v_fetch(), "andi_fetch"); push(v_decode(1'b1), "andi_illegal");
    run(2);
`endif

    // Abandon an lw in MEMRD with an asynchronous reset pulse
    issue(6'b100011, 6'b000000, 1'b0);
    push(v_fetch(), "rlw_fetch"); push(v_decode(1'b0), "rlw_decode"); push(v_memadr(), "rlw_memadr");
    push(v_memrd(), "rlw_memrd");
    run(3);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    push(v_rst(), "rst_mid_memrd"); -> sample_ev;
    @(posedge clk); #1;
    push(v_rst(), "rst_held_edge"); -> sample_ev;
    #1 rst_n = 1'b1;
    #1;

    issue(6'b000010, 6'b000000, 1'b0);
    push(v_fetch(), "post_rst_fetch"); push(v_decode(1'b0), "post_rst_decode"); push(v_jump(), "post_rst_jump");
    run(3);

    @(negedge clk); #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
